// File: rtl/rnn_input_feeder.sv
// Byte-to-vector packer, vector FIFO and start handshake feeding the RNN core.
// Build option: define RNN_FEED_UNDERFLOW_HOLD_EN to hold idata on underflow.
module rnn_input_feeder #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned START_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic                     busy,
    input  logic                     i_en,
    output logic                     ready,
    output logic [31:0]              idata,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   vec_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [1:0]     byte_idx;
    logic [31:0]    word_buf;
    logic [31:0]    word_asm;
    logic           xfer;
    logic           push;
    logic           pop;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           frame_end;
    logic [31:0]    idata_r;
    logic           underflow_r;

    // Bytes above byte_idx are always zero in word_buf, so an early s_last
    // yields a zero-padded word without extra masking.
    assign s_ready   = !reset && (count != CW'(DEPTH));
    assign xfer      = s_valid && s_ready;
    assign word_asm  = word_buf | ({24'h0, s_data} << {byte_idx, 3'b000});
    assign push      = xfer && ((byte_idx == 2'd3) || s_last);
    assign pop       = i_en && (count != '0);

    assign vec_count = count;
    assign idata     = idata_r;
    assign underflow = underflow_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx <= '0;
            word_buf <= '0;
        end else if (xfer) begin
            if (push) begin
                byte_idx <= '0;
                word_buf <= '0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
                word_buf <= word_asm;
            end
        end
    end

    // A push only follows an accepted byte, and bytes are refused when full.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word_asm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idata_r     <= '0;
            underflow_r <= 1'b0;
        end else if (i_en) begin
            if (count != '0) begin
                idata_r <= mem[rd_ptr];
            end else begin
                underflow_r <= 1'b1;
`ifdef RNN_FEED_UNDERFLOW_HOLD_EN
                idata_r     <= idata_r;
`else
                idata_r     <= '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_end <= 1'b0;
        end else begin
            state <= state_next;
            // A frame ending on the same edge the core finishes is kept.
            if (push && s_last) begin
                frame_end <= 1'b1;
            end else if (state == RUN && !busy) begin
                frame_end <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if ((count >= CW'(START_THRESH)) || (frame_end && (count != '0))) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                ready = 1'b1;
                if (busy) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rnn_input_feeder.sv
// Self-checking bench for rnn_input_feeder: directed scenarios plus a random
// byte/i_en stream compared against a queue-based reference model.
module tb_rnn_input_feeder;

    localparam int unsigned DEPTH        = 16;
    localparam int unsigned START_THRESH = 4;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_last  = 1'b0;
    logic        busy    = 1'b0;
    logic        i_en    = 1'b0;
    logic        s_ready;
    logic        ready;
    logic [31:0] idata;
    logic        underflow;
    logic [4:0]  vec_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of whole words plus pending bytes of the open word.
    logic [31:0] mq[$];
    logic [7:0]  mb[$];
    logic [31:0] m_idata = 32'h0;
    logic        m_uf    = 1'b0;

    rnn_input_feeder #(
        .DEPTH        (DEPTH),
        .START_THRESH (START_THRESH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .busy      (busy),
        .i_en      (i_en),
        .ready     (ready),
        .idata     (idata),
        .underflow (underflow),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit          accept;
        logic [31:0] w;
        if (reset) begin
            mq.delete();
            mb.delete();
            m_idata = 32'h0;
            m_uf    = 1'b0;
            return;
        end
        accept = s_valid && (mq.size() < DEPTH);
        if (i_en) begin
            if (mq.size() > 0) begin
                m_idata = mq.pop_front();
            end else begin
                m_uf = 1'b1;
`ifndef RNN_FEED_UNDERFLOW_HOLD_EN
                m_idata = 32'h0;
`endif
            end
        end
        if (accept) begin
            mb.push_back(s_data);
            if (mb.size() == 4 || s_last) begin
                w = 32'h0;
                foreach (mb[k]) w = w | (32'(mb[k]) << (8 * k));
                mq.push_back(w);
                mb.delete();
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic ie);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        i_en    = ie;
        model_edge();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        i_en    = 1'b0;
    endtask

    task automatic do_reset();
        busy  = 1'b0;
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) step(1'b1, w[8*k +: 8], 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b1);
        n_vec++;
        if (s_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_s_ready_low: got %b expected 0", s_ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        n_vec++;
        if (vec_count !== 5'd0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", vec_count);
        end
        n_vec++;
        if (ready !== 1'b0 || underflow !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got ready=%b uf=%b expected 0 0", ready, underflow);
        end
        n_vec++;
        if (idata !== 32'h0) begin
            n_err++; $display("FAIL reset_idata: got %h expected 00000000", idata);
        end
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready);
        end
    endtask

    task automatic test_pack();
        do_reset();
        push_word(32'h44332211);
        push_word(32'h88776655);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (vec_count !== 5'd2) begin
            n_err++; $display("FAIL pack_count: got %0d expected 2", vec_count);
        end
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL pack_ready_below_thresh: got %b expected 0", ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'h44332211 || vec_count !== 5'd1) begin
            n_err++; $display("FAIL pack_first_pop: got %h/%0d expected 44332211/1", idata, vec_count);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (idata !== 32'h44332211) begin
            n_err++; $display("FAIL pack_idata_hold: got %h expected 44332211", idata);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'h88776655 || vec_count !== 5'd0) begin
            n_err++; $display("FAIL pack_second_pop: got %h/%0d expected 88776655/0", idata, vec_count);
        end
    endtask

    task automatic test_start_fsm();
        do_reset();
        for (int v = 0; v < 3; v++) push_word($urandom);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL fsm_three_vectors: got ready=%b expected 0", ready);
        end
        push_word($urandom);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (ready !== 1'b1 || vec_count !== 5'd4) begin
            n_err++; $display("FAIL fsm_armed: got ready=%b count=%0d expected 1 4", ready, vec_count);
        end
        busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n_vec++;
            if (ready !== 1'b0) begin
                n_err++; $display("FAIL fsm_busy_cycle%0d: got ready=%b expected 0", c, ready);
            end
        end
        busy = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL fsm_busy_fall: got ready=%b expected 0", ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL fsm_rearm: got ready=%b expected 1", ready);
        end
    endtask

    task automatic test_frame_end();
        do_reset();
        push_word(32'h04030201);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        n_vec++;
        if (vec_count !== 5'd2 || ready !== 1'b0) begin
            n_err++; $display("FAIL frame_push: got count=%0d ready=%b expected 2 0", vec_count, ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL frame_ready_early: got ready=%b expected 1", ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'h000000AA) begin
            n_err++; $display("FAIL frame_padded: got %h expected 000000AA", idata);
        end
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'h0000CCBB) begin
            n_err++; $display("FAIL frame_two_bytes: got %h expected 0000CCBB", idata);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int v = 0; v < 16; v++) push_word(32'hA0000000 | 32'(v));
        for (int c = 0; c < 3; c++) step(1'b1, 8'hEE, 1'b0, 1'b0);
        n_vec++;
        if (vec_count !== 5'd16 || s_ready !== 1'b0) begin
            n_err++; $display("FAIL full_stall: got count=%0d s_ready=%b expected 16 0", vec_count, s_ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (vec_count !== 5'd15 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL full_release: got count=%0d s_ready=%b expected 15 1", vec_count, s_ready);
        end
        n_vec++;
        if (idata !== 32'hA0000000) begin
            n_err++; $display("FAIL full_head: got %h expected A0000000", idata);
        end
        for (int v = 1; v < 16; v++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            n_vec++;
            if (idata !== m_idata) begin
                n_err++; $display("FAIL full_drain%0d: got %h expected %h", v, idata, m_idata);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        push_word(32'hDEADBEEF);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'hDEADBEEF || underflow !== 1'b0) begin
            n_err++; $display("FAIL uf_preload: got %h uf=%b expected DEADBEEF 0", idata, underflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
`ifdef RNN_FEED_UNDERFLOW_HOLD_EN
        if (idata !== 32'hDEADBEEF || underflow !== 1'b1) begin
            n_err++; $display("FAIL uf_event: got %h uf=%b expected DEADBEEF 1", idata, underflow);
        end
`else
        if (idata !== 32'h0 || underflow !== 1'b1) begin
            n_err++; $display("FAIL uf_event: got %h uf=%b expected 00000000 1", idata, underflow);
        end
`endif
        push_word(32'h12345678);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (underflow !== 1'b1 || idata !== 32'h12345678) begin
            n_err++; $display("FAIL uf_sticky: got uf=%b idata=%h expected 1 12345678", underflow, idata);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_word(32'hCAFEF00D);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'hCAFEF00D || vec_count !== 5'd1) begin
            n_err++; $display("FAIL simul_push_pop: got %h/%0d expected CAFEF00D/1", idata, vec_count);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'h04030201) begin
            n_err++; $display("FAIL simul_next: got %h expected 04030201", idata);
        end
        push_word(32'h0BADF00D);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'h98, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        n_vec++;
        if (vec_count !== 5'd0 || ready !== 1'b0 || idata !== 32'h0) begin
            n_err++; $display("FAIL midreset: got count=%0d ready=%b idata=%h expected 0 0 00000000",
                              vec_count, ready, idata);
        end
        push_word(32'h44332211);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++;
        if (idata !== 32'h44332211) begin
            n_err++; $display("FAIL midreset_partial_dropped: got %h expected 44332211", idata);
        end
    endtask

    task automatic test_random();
        logic v, l, ie;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 9) < 7);
            l  = ($urandom_range(0, 9) == 0);
            ie = ($urandom_range(0, 3) == 0);
            step(v, 8'($urandom), l, ie);
            n_vec++;
            if (vec_count !== mq.size()) begin
                n_err++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, vec_count, mq.size());
            end
            n_vec++;
            if (s_ready !== (mq.size() < DEPTH)) begin
                n_err++; $display("FAIL rand_s_ready@%0d: got %b expected %b", c, s_ready, mq.size() < DEPTH);
            end
            n_vec++;
            if (idata !== m_idata || underflow !== m_uf) begin
                n_err++; $display("FAIL rand_idata@%0d: got %h uf=%b expected %h uf=%b",
                                  c, idata, underflow, m_idata, m_uf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_start_fsm();
        test_frame_end();
        test_full();
        test_underflow();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
